// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg: shared op codes, FSM states and step limit for the iterative shifter
package alu_shift_pkg;
    localparam logic [1:0] SHIFT_OP_SLL  = 2'b00;
    localparam logic [1:0] SHIFT_OP_SRL  = 2'b01;
    localparam logic [1:0] SHIFT_OP_SRA  = 2'b10;
    localparam logic [1:0] SHIFT_OP_ROTL = 2'b11;
    localparam logic [2:0] STEP_LAST     = 3'd4;
    typedef enum logic {S_IDLE, S_RUN} state_t;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: fixed-distance combinational shifter; op 11 rotates left when ROTATE_EN is defined, else passes through
module shift_stage
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out
);
    // Select the shifted form for the requested operation
    always_comb begin
        out = op == SHIFT_OP_SLL ? in << DIST :
              op == SHIFT_OP_SRL ? in >> DIST :
              op == SHIFT_OP_SRA ? WIDTH'($signed(in) >>> DIST) :
`ifdef ROTATE_EN
              {in[WIDTH-DIST-1:0], in[WIDTH-1:WIDTH-DIST]};
`else
              in;
`endif
    end
endmodule

// File: rtl/iter_shift_unit.sv
// iter_shift_unit: 5-cycle iterative shifter applying one power-of-two stage per clock (optional ROTATE_EN)
module iter_shift_unit
    import alu_shift_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_shift,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] data_shamt,
    input  logic [1:0]         shift_op,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);
    state_t             state, state_next;
    logic [2:0]         step;
    logic [WIDTH-1:0]   work, stage_in;
    logic [SHAMT_W-1:0] shamt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   stage_out [SHAMT_W];

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        shift_stage #(.WIDTH(WIDTH), .DIST(1 << i)) u_stage (
            .in (work),
            .op (op_q),
            .out(stage_out[i])
        );
    end

    assign busy = state == S_RUN;

    // Working value after this cycle's stage: shifted only when the matching shamt bit is set
    always_comb begin
        stage_in = shamt_q[step] ? stage_out[step] : work;
    end

    // Next state: start only from idle, finish after the last stage
    always_comb begin
        state_next = state;
        state_next = state == S_IDLE ? (ctrl_shift ? S_RUN : S_IDLE) :
                     step == STEP_LAST ? S_IDLE : S_RUN;
    end

    // State register
    always_ff @(posedge clock) begin
        state <= reset ? S_IDLE : state_next;
    end

    // Operand capture, per-stage update and result publication
    always_ff @(posedge clock) begin
        if (reset) begin
            step           <= '0;
            work           <= '0;
            shamt_q        <= '0;
            op_q           <= '0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (state == S_IDLE && ctrl_shift) begin
                work    <= data_operandA;
                shamt_q <= data_shamt;
                op_q    <= shift_op;
                step    <= '0;
            end else if (state == S_RUN) begin
                work <= stage_in;
                step <= step == STEP_LAST ? 3'd0 : step + 3'd1;
                if (step == STEP_LAST) begin
                    data_result    <= stage_in;
                    data_resultRDY <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_iter_shift_unit.sv
// tb_iter_shift_unit: directed table plus multi-cycle sequences for iter_shift_unit (ROTATE_EN aware)
module tb_iter_shift_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_shift = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [4:0]  data_shamt = '0;
    logic [1:0]  shift_op = '0;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[13];

    iter_shift_unit dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_shift    (ctrl_shift),
        .data_operandA (data_operandA),
        .data_shamt    (data_shamt),
        .shift_op      (shift_op),
        .data_result   (data_result),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh);
        shift_op = op;
        data_operandA = a;
        data_shamt = sh;
        ctrl_shift = 1'b1;
        tick();
        ctrl_shift = 1'b0;
        data_operandA = 32'h5A5A_5A5A;
        data_shamt = 5'd7;
        shift_op = 2'b01;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (!data_resultRDY && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic count_rdy(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (data_resultRDY) n++;
        end
    endtask

    initial begin
        int n, m;
        vecs[0]  = '{2'b00, 32'h0000_00F1, 5'd4,  32'h0000_0F10, "sll_f1_4"};
        vecs[1]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, "srl_msb_31"};
        vecs[2]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "sra_msb_31"};
        vecs[3]  = '{2'b10, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, "sra_pos_4"};
        vecs[4]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "sll_0"};
        vecs[5]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "srl_0"};
        vecs[6]  = '{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "sra_0"};
        vecs[7]  = '{2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "op11_0"};
        vecs[8]  = '{2'b00, 32'h1234_5678, 5'd13, 32'h8ACF_0000, "sll_13"};
        vecs[9]  = '{2'b01, 32'hF000_0000, 5'd5,  32'h0780_0000, "srl_5"};
        vecs[10] = '{2'b10, 32'hF000_0000, 5'd5,  32'hFF80_0000, "sra_5"};
        vecs[11] = '{2'b10, 32'h8000_0000, 5'd1,  32'hC000_0000, "sra_1"};
`ifdef ROTATE_EN
        vecs[12] = '{2'b11, 32'h8000_0001, 5'd1,  32'h0000_0003, "rotl_1"};
`else
        vecs[12] = '{2'b11, 32'h8000_0001, 5'd1,  32'h8000_0001, "pass_1"};
`endif
        tick();
        tick();
        reset = 1'b0;
        check("reset_result", data_result, 32'h0);
        check("reset_rdy", {31'h0, data_resultRDY}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        tick();

        for (int i = 0; i < 13; i++) begin
            start(vecs[i].op, vecs[i].a, vecs[i].sh);
            check({vecs[i].name, "_busy"}, {31'h0, busy}, 32'h1);
            wait_rdy(n);
            check({vecs[i].name, "_latency"}, n, 32'd5);
            check({vecs[i].name, "_result"}, data_result, vecs[i].exp);
            check({vecs[i].name, "_busy_done"}, {31'h0, busy}, 32'h0);
            tick();
            check({vecs[i].name, "_rdy_pulse"}, {31'h0, data_resultRDY}, 32'h0);
            check({vecs[i].name, "_hold"}, data_result, vecs[i].exp);
        end

        start(2'b00, 32'hDEAD_BEEF, 5'd0);
        tick();
        shift_op = 2'b00;
        data_operandA = 32'h0000_0001;
        data_shamt = 5'd1;
        ctrl_shift = 1'b1;
        tick();
        ctrl_shift = 1'b0;
        wait_rdy(m);
        check("ignore_latency", m, 32'd3);
        check("ignore_result", data_result, 32'hDEAD_BEEF);
        count_rdy(10, n);
        check("ignore_single_rdy", n, 32'd0);

        start(2'b00, 32'h0000_0001, 5'd1);
        wait_rdy(n);
        check("b2b_first", data_result, 32'h0000_0002);
        start(2'b00, 32'h0000_0001, 5'd31);
        check("b2b_accepted_busy", {31'h0, busy}, 32'h1);
        wait_rdy(n);
        check("b2b_latency", n, 32'd5);
        check("b2b_second", data_result, 32'h8000_0000);
        tick();

        start(2'b00, 32'hFFFF_FFFF, 5'd8);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_result", data_result, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_rdy", {31'h0, data_resultRDY}, 32'h0);
        count_rdy(8, n);
        check("abort_no_rdy", n, 32'd0);
        check("abort_result_hold", data_result, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
Multicycle shift unit for the ALU execute path. It applies fixed power-of-two shift stages (1, 2, 4, 8, 16), one stage per clock. Each stage is applied only if the matching shamt bit is set.
- Trades the combinational barrel-shifter depth for a 5-cycle latency.
- Uses the same ctrl/resultRDY handshake as the multiplier/divider.
- Its result feeds the execute-stage result mux.

Parameters:
WIDTH, 32, data width; must be a power of two; only 32 is required to be supported.
SHAMT_W, $clog2(WIDTH) = 5, shift-amount width (localparam, derived, not overridable).

Ports:
clock  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
ctrl_shift  input  1  start pulse; sampled only when idle.
data_operandA  input  WIDTH  value to shift.
data_shamt  input  SHAMT_W  shift amount, 0..31.
shift_op  input  2  operation: 00 sll, 01 srl, 10 sra, 11 reserved (rotl with ROTATE_EN).
data_result  output  WIDTH  result of the last completed operation.
data_resultRDY  output  1  one-cycle pulse when data_result is updated.
busy  output  1  high while an operation is in progress.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; the step counter goes to 0.
  - data_result = 0, data_resultRDY = 0, busy = 0.
  - Reset dominates every other input.
- States: IDLE and RUN. The step counter is 3 bits, counting 0..4.
- IDLE:
  - If ctrl_shift=1 at edge k: latch operand, shamt and op; step=0; go to RUN; busy=1 from cycle k+1.
  - Otherwise stay in IDLE.
- RUN, on each edge:
  - If shamt_q[step]=1, the working register takes the stage output for distance 2^step. Otherwise it holds.
  - step increments.
  - At step==4 the edge writes the final value to data_result, pulses data_resultRDY high for exactly one cycle, clears busy and returns to IDLE.
- Latency: with start sampled at edge k, data_result is valid and data_resultRDY=1 in the cycle following edge k+5. This is fixed and independent of shamt.
- Stage arithmetic:
  - sll: zero-fill from the LSB side.
  - srl: zero-fill from the MSB side.
  - sra: replicate operand bit WIDTH-1.
  - Bits shifted out are discarded.
- shamt=0: result equals the operand after the full 5-cycle latency.
- shamt=31 under sra: result is all copies of the sign bit.
- op=11 without ROTATE_EN: the operand passes through unchanged, with normal latency and an RDY pulse.
- ctrl_shift while busy: ignored entirely. Latched inputs do not change.
- ctrl_shift in the same cycle as the data_resultRDY pulse is accepted (the FSM is already in IDLE), which allows back-to-back operations with a 5-cycle issue interval.
- data_result holds its value between completions. It is not cleared when a new operation starts.
- Inputs may change after the start cycle without affecting the operation.
- Reset during RUN aborts the operation: no RDY pulse, result returns to 0.

Optional Feature:
ROTATE_EN:
- When defined, op=11 is rotate-left: each stage wraps the bits shifted out of the MSB into the LSB.
- When undefined, op=11 is pass-through and no rotate logic is synthesised.

Decomposition:
- Shared package alu_shift_pkg holds:
  - SHIFT_OP_SLL=2'b00, SHIFT_OP_SRL=2'b01, SHIFT_OP_SRA=2'b10, SHIFT_OP_ROTL=2'b11;
  - the FSM state enum {S_IDLE, S_RUN};
  - STEP_LAST=3'd4.
- One natural sub-module, shift_stage: a combinational fixed-distance shifter.
  - Parameter DIST; inputs in[WIDTH-1:0] and op.
  - Instantiated five times (DIST = 1, 2, 4, 8, 16).
  - The step counter selects which instance's output is used.

Test Plan:
1. Reset, then sll of 0x000000F1 with shamt=4 → data_result=0x00000F10; RDY pulse exactly 5 cycles after start; busy high for 5 cycles.
2. srl 0x80000000, shamt=31 → 0x00000001. sra 0x80000000, shamt=31 → 0xFFFFFFFF. sra 0x7FFFFFF0, shamt=4 → 0x07FFFFFF.
3. shamt=0 on 0xDEADBEEF under each op → result 0xDEADBEEF after 5 cycles; a second ctrl_shift asserted while busy → ignored, only one RDY pulse.
4. Back-to-back: start sll 0x1 by 1 → 0x00000002. Assert a new start (sll 0x1 by 31) in the RDY cycle → accepted; the second result 0x80000000 arrives 5 cycles later.
5. Reset asserted at the third RUN cycle of sll 0xFFFFFFFF by 8 → no RDY pulse; data_result=0, busy=0 the cycle after reset.
6. op=11 on 0x80000001, shamt=1 → 0x00000003 with ROTATE_EN defined; 0x80000001 without it.
